// File: rtl/stopwatch_datapath.sv
// -----------------------------------------------------------------------------
// stopwatch_datapath
//
// Time-keeping datapath for the stopwatch. A clock divider derives a
// centisecond time base from the system clock. On each time-base tick the
// cascaded msec/sec/min/hour counters advance. All carries resolve in a
// single clock edge, so no partially-carried value is ever visible.
// Button handling lives in the control FSM. This block only follows the
// run_stop level and the clear request.
//
// Parameters
//   CLK_FREQ : system clock frequency in Hz
//   TICK_HZ  : time-base rate in Hz (one tick = one centisecond)
//
// Ports
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   run_stop : 1 = counting, 0 = paused (all state frozen, divider included)
//   clear    : synchronous zeroing of all time state; may be held
//   msec     : centiseconds 0..99   (registered)
//   sec      : seconds      0..59   (registered)
//   min      : minutes      0..59   (registered)
//   hour     : hours        0..23   (registered)
//   tick     : one-cycle pulse on every time-base tick (registered)
//   day_wrap : one-cycle pulse when 23:59:59.99 rolls to 00:00:00.00
// -----------------------------------------------------------------------------
module stopwatch_datapath #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run_stop,
   input  logic       clear,
   output logic [6:0] msec,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       tick,
   output logic       day_wrap
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [6:0]    MSEC_MAX = 7'd99;
   localparam logic [5:0]    SEC_MAX  = 6'd59;
   localparam logic [5:0]    MIN_MAX  = 6'd59;
   localparam logic [4:0]    HOUR_MAX = 5'd23;

   // State registers
   logic [CW-1:0] tick_cnt_r;
   logic [6:0]    msec_r;
   logic [5:0]    sec_r;
   logic [5:0]    min_r;
   logic [4:0]    hour_r;
   logic          tick_r;
   logic          day_wrap_r;

   // Combinational next values
   logic          tick_event_s;
   logic [CW-1:0] tick_cnt_next_s;
   logic [6:0]    msec_next_s;
   logic [5:0]    sec_next_s;
   logic [5:0]    min_next_s;
   logic [4:0]    hour_next_s;
   logic          msec_carry_s;
   logic          sec_carry_s;
   logic          min_carry_s;
   logic          hour_carry_s;

   // Time base: a tick fires when the divider sits on its last count while running.
   // Treating any count >= the last value as terminal lets a corrupted divider recover.
   always_comb begin
      tick_event_s    = 1'b0;
      tick_cnt_next_s = tick_cnt_r;
      if (run_stop) begin
         if (tick_cnt_r >= CNT_LAST) begin
            tick_event_s    = 1'b1;
            tick_cnt_next_s = {CW{1'b0}};
         end else begin
            tick_event_s    = 1'b0;
            tick_cnt_next_s = tick_cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         tick_event_s    = 1'b0;
         tick_cnt_next_s = tick_cnt_r;
      end
   end

   // Centiseconds: the field always advances on a tick. Out-of-range values are
   // forced to zero without generating a carry.
   always_comb begin
      msec_next_s  = msec_r;
      msec_carry_s = 1'b0;
      if (msec_r > MSEC_MAX) begin
         msec_next_s  = 7'd0;
         msec_carry_s = 1'b0;
      end else if (msec_r == MSEC_MAX) begin
         msec_next_s  = 7'd0;
         msec_carry_s = 1'b1;
      end else begin
         msec_next_s  = msec_r + 7'd1;
         msec_carry_s = 1'b0;
      end
   end

   // Seconds: advance only on a carry from centiseconds. Out-of-range values clear on any tick.
   always_comb begin
      sec_next_s  = sec_r;
      sec_carry_s = 1'b0;
      if (sec_r > SEC_MAX) begin
         sec_next_s  = 6'd0;
         sec_carry_s = 1'b0;
      end else if (msec_carry_s) begin
         if (sec_r == SEC_MAX) begin
            sec_next_s  = 6'd0;
            sec_carry_s = 1'b1;
         end else begin
            sec_next_s  = sec_r + 6'd1;
            sec_carry_s = 1'b0;
         end
      end else begin
         sec_next_s  = sec_r;
         sec_carry_s = 1'b0;
      end
   end

   // Minutes: advance only on a carry from seconds. Out-of-range values clear on any tick.
   always_comb begin
      min_next_s  = min_r;
      min_carry_s = 1'b0;
      if (min_r > MIN_MAX) begin
         min_next_s  = 6'd0;
         min_carry_s = 1'b0;
      end else if (sec_carry_s) begin
         if (min_r == MIN_MAX) begin
            min_next_s  = 6'd0;
            min_carry_s = 1'b1;
         end else begin
            min_next_s  = min_r + 6'd1;
            min_carry_s = 1'b0;
         end
      end else begin
         min_next_s  = min_r;
         min_carry_s = 1'b0;
      end
   end

   // Hours: advance only on a carry from minutes. A carry out of 23 is the day wrap.
   always_comb begin
      hour_next_s  = hour_r;
      hour_carry_s = 1'b0;
      if (hour_r > HOUR_MAX) begin
         hour_next_s  = 5'd0;
         hour_carry_s = 1'b0;
      end else if (min_carry_s) begin
         if (hour_r == HOUR_MAX) begin
            hour_next_s  = 5'd0;
            hour_carry_s = 1'b1;
         end else begin
            hour_next_s  = hour_r + 5'd1;
            hour_carry_s = 1'b0;
         end
      end else begin
         hour_next_s  = hour_r;
         hour_carry_s = 1'b0;
      end
   end

   // Divider register: clear wins over run_stop; frozen while paused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_r <= {CW{1'b0}};
      end else if (clear) begin
         tick_cnt_r <= {CW{1'b0}};
      end else begin
         tick_cnt_r <= tick_cnt_next_s;
      end
   end

   // Time fields: all four update together on the tick edge, so carries never show half-done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msec_r <= 7'd0;
         sec_r  <= 6'd0;
         min_r  <= 6'd0;
         hour_r <= 5'd0;
      end else if (clear) begin
         msec_r <= 7'd0;
         sec_r  <= 6'd0;
         min_r  <= 6'd0;
         hour_r <= 5'd0;
      end else if (tick_event_s) begin
         msec_r <= msec_next_s;
         sec_r  <= sec_next_s;
         min_r  <= min_next_s;
         hour_r <= hour_next_s;
      end
   end

   // Event pulses: low by default, high for the single cycle following a tick edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_r     <= 1'b0;
         day_wrap_r <= 1'b0;
      end else if (clear) begin
         tick_r     <= 1'b0;
         day_wrap_r <= 1'b0;
      end else begin
         tick_r     <= tick_event_s;
         day_wrap_r <= tick_event_s & hour_carry_s;
      end
   end

   assign msec     = msec_r;
   assign sec      = sec_r;
   assign min      = min_r;
   assign hour     = hour_r;
   assign tick     = tick_r;
   assign day_wrap = day_wrap_r;

endmodule
